// File: rtl/ring_osc_dco.sv
// Counter-based emulation of the ADPLL ring-oscillator DCO: 50% duty square wave on clk_o.
// Optional RING_OSC_SYNC_EN adds 2-flop synchronisers on enable_i and freq_sel_i.
module ring_osc_dco #(
    parameter int CTRL_WIDTH = 5,
    parameter int MIN_HALF   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    input  logic [CTRL_WIDTH-1:0] freq_sel_i,
    output logic                  clk_o
);
    localparam int N     = 2 ** CTRL_WIDTH;
    localparam int CNT_W = $clog2(MIN_HALF + N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [CTRL_WIDTH-1:0] act_code;
    logic                  en;
    logic [CTRL_WIDTH-1:0] sel;
    logic [CNT_W-1:0]      last_cnt;
    logic                  phase_end;

`ifdef RING_OSC_SYNC_EN
    logic [1:0]            en_sync;
    logic [CTRL_WIDTH-1:0] sel_meta;
    logic [CTRL_WIDTH-1:0] sel_sync;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_sync  <= '0;
            sel_meta <= '0;
            sel_sync <= '0;
        end else begin
            en_sync  <= {en_sync[0], enable_i};
            sel_meta <= freq_sel_i;
            sel_sync <= sel_meta;
        end
    end

    assign en  = en_sync[1];
    assign sel = sel_sync;
`else
    assign en  = enable_i;
    assign sel = freq_sel_i;
`endif

    // Terminal count is H-1 = (MIN_HALF-1) + (N-1-code).
    assign last_cnt  = CNT_W'(MIN_HALF - 1 + N - 1) - CNT_W'(act_code);
    assign phase_end = (cnt == last_cnt);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            cnt      <= '0;
            act_code <= '0;
            clk_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clk_o <= 1'b0;
                    cnt   <= '0;
                    if (en) begin
                        act_code <= sel;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (phase_end) begin
                            clk_o    <= ~clk_o;
                            cnt      <= '0;
                            act_code <= sel;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (!clk_o) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (phase_end) begin
                        // Disable landed on the last cycle of the high phase.
                        clk_o <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (en) begin
                        state <= RUN;
                    end else if (phase_end) begin
                        clk_o <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    clk_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ring_osc_dco.sv
// Directed bench for ring_osc_dco (CTRL_WIDTH=5, MIN_HALF=1); edge counts are hand-derived.
module tb_ring_osc_dco;
    localparam int CTRL_WIDTH = 5;
`ifdef RING_OSC_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LIMIT = 300;

    logic                  clk_i = 1'b0;
    logic                  rst_n_i = 1'b0;
    logic                  enable_i = 1'b0;
    logic [CTRL_WIDTH-1:0] freq_sel_i = '0;
    logic                  clk_o;

    int errors = 0;
    int checks = 0;

    ring_osc_dco #(.CTRL_WIDTH(CTRL_WIDTH), .MIN_HALF(1)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .enable_i   (enable_i),
        .freq_sel_i (freq_sel_i),
        .clk_o      (clk_o)
    );

    always #5 clk_i = ~clk_i;

    // Edges until clk_o reaches level; sampled 1ns after each rising edge, bounded by LIMIT.
    task automatic count_until(input logic level, output int n);
        n = 0;
        while (clk_o !== level && n < LIMIT) begin
            @(posedge clk_i);
            #1;
            n++;
        end
    endtask

    task automatic count_highs(input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_i);
            #1;
            if (clk_o !== 1'b0) highs++;
        end
    endtask

    task automatic test_reset();
        int h;
        rst_n_i = 1'b0;
        enable_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (clk_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_clk_o: got %b expected 0", clk_o);
        end
        rst_n_i = 1'b1;
        count_highs(1000, h);
        checks++;
        if (h !== 0) begin
            errors++;
            $display("FAIL idle_low: got %0d high samples expected 0", h);
        end
    endtask

    task automatic test_start();
        int n;
        freq_sel_i = 5'd0;
        enable_i = 1'b1;
        @(posedge clk_i);
        #1;
        count_until(1'b1, n);
        checks++;
        if (n !== 32 + SYNC_LAT) begin
            errors++;
            $display("FAIL start_first_rise: got %0d expected %0d", n, 32 + SYNC_LAT);
        end
        count_until(1'b0, n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL start_high: got %0d expected 32", n);
        end
        count_until(1'b1, n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL start_low: got %0d expected 32", n);
        end
    endtask

    task automatic test_codes();
        logic [CTRL_WIDTH-1:0] codes[5];
        int periods[5];
        int old_high;
        int f, n1, n2, n3;
        codes   = '{5'd1, 5'd2, 5'd6, 5'd15, 5'd31};
        periods = '{62, 60, 52, 34, 2};
        old_high = 32;
        for (int i = 0; i < 5; i++) begin
            freq_sel_i = codes[i];
            count_until(1'b0, f);
            checks++;
            if (f !== old_high) begin
                errors++;
                $display("FAIL code%0d_old_high: got %0d expected %0d", codes[i], f, old_high);
            end
            count_until(1'b1, n1);
            count_until(1'b0, n2);
            count_until(1'b1, n3);
            checks++;
            if (n1 + n2 !== periods[i]) begin
                errors++;
                $display("FAIL code%0d_period: got %0d expected %0d", codes[i], n1 + n2, periods[i]);
            end
            old_high = periods[i] / 2;
        end
    endtask

    task automatic test_stop_high();
        int n, h;
        enable_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        freq_sel_i = 5'd15;
        enable_i = 1'b1;
        @(posedge clk_i);
        #1;
        count_until(1'b1, n);
        checks++;
        if (n !== 17 + SYNC_LAT) begin
            errors++;
            $display("FAIL stop_high_rise: got %0d expected %0d", n, 17 + SYNC_LAT);
        end
        repeat (3) @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        count_until(1'b0, n);
        checks++;
        if (n !== 14) begin
            errors++;
            $display("FAIL stop_high_remaining: got %0d expected 14", n);
        end
        count_highs(100, h);
        checks++;
        if (h !== 0) begin
            errors++;
            $display("FAIL stop_high_parked: got %0d high samples expected 0", h);
        end
    endtask

    task automatic test_stop_low();
        int n, h;
        freq_sel_i = 5'd15;
        enable_i = 1'b1;
        @(posedge clk_i);
        #1;
        count_until(1'b1, n);
        checks++;
        if (n !== 17 + SYNC_LAT) begin
            errors++;
            $display("FAIL stop_low_rise: got %0d expected %0d", n, 17 + SYNC_LAT);
        end
        count_until(1'b0, n);
        checks++;
        if (n !== 17) begin
            errors++;
            $display("FAIL stop_low_high: got %0d expected 17", n);
        end
        repeat (5) @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        count_highs(100, h);
        checks++;
        if (h !== 0) begin
            errors++;
            $display("FAIL stop_low_parked: got %0d high samples expected 0", h);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        freq_sel_i = 5'd0;
        enable_i = 1'b1;
        @(posedge clk_i);
        #1;
        count_until(1'b1, n);
        checks++;
        if (n !== 32 + SYNC_LAT) begin
            errors++;
            $display("FAIL rst_mid_rise: got %0d expected %0d", n, 32 + SYNC_LAT);
        end
        repeat (5) @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (clk_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got %b expected 0", clk_o);
        end
        enable_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        enable_i = 1'b1;
        @(posedge clk_i);
        #1;
        count_until(1'b1, n);
        checks++;
        if (n !== 32 + SYNC_LAT) begin
            errors++;
            $display("FAIL restart_rise: got %0d expected %0d", n, 32 + SYNC_LAT);
        end
        count_until(1'b0, n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL restart_high: got %0d expected 32", n);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_codes();
        test_stop_high();
        test_stop_low();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
